// File: rtl/regfile_wb_arbiter_if.sv
// Bundle between the execute/memory stages, decode and the register file write port.
// The slave side is the writeback arbiter; the master side is everything around it.
interface regfile_wb_arbiter_if #(
   parameter int XLEN  = 32,
   parameter int NREGS = 32,
   parameter int AW    = 5
);
   logic             alu_valid_in;
   logic [AW-1:0]    alu_rd_in;
   logic [XLEN-1:0]  alu_data_in;
   logic             alu_ready_out;
   logic             ld_valid_in;
   logic [AW-1:0]    ld_rd_in;
   logic [XLEN-1:0]  ld_data_in;
   logic             issue_ld_in;
   logic [AW-1:0]    issue_rd_in;
   logic [AW-1:0]    rs1_sel_in;
   logic [AW-1:0]    rs2_sel_in;
   logic             hazard_out;
   logic             write_enable_out;
   logic [AW-1:0]    rd_sel_out;
   logic [XLEN-1:0]  write_data_out;
   logic [NREGS-1:0] pending_out;
   logic             err_out;

   modport master (
      output alu_valid_in, alu_rd_in, alu_data_in,
      output ld_valid_in, ld_rd_in, ld_data_in,
      output issue_ld_in, issue_rd_in, rs1_sel_in, rs2_sel_in,
      input  alu_ready_out, hazard_out, write_enable_out, rd_sel_out,
      input  write_data_out, pending_out, err_out
   );

   modport slave (
      input  alu_valid_in, alu_rd_in, alu_data_in,
      input  ld_valid_in, ld_rd_in, ld_data_in,
      input  issue_ld_in, issue_rd_in, rs1_sel_in, rs2_sel_in,
      output alu_ready_out, hazard_out, write_enable_out, rd_sel_out,
      output write_data_out, pending_out, err_out
   );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates the register file write port between load and ALU writeback and
// tracks outstanding loads so decode can stall on not-yet-readable sources.
module regfile_wb_arbiter #(
   parameter int XLEN  = 32,
   parameter int NREGS = 32,
   parameter int AW    = 5
) (
   input logic                 clk,
   input logic                 rst,
   regfile_wb_arbiter_if.slave bus
);

   logic             hold_valid;
   logic [AW-1:0]    hold_rd;
   logic [XLEN-1:0]  hold_data;
   logic [NREGS-1:0] pending;
   logic             err;

   logic             vld_p0;
   logic [AW-1:0]    rd_p0;
   logic [XLEN-1:0]  data_p0;

   logic             alu_ready;
   logic             alu_acc;
   logic             grant;
   logic [AW-1:0]    grant_rd;
   logic [XLEN-1:0]  grant_data;
   logic             err_set;
   logic [NREGS-1:0] pending_nxt;

   // A source is unreadable while its load is outstanding or its value is
   // still in the hold buffer or the output stage.
   function automatic logic src_hazard(
      input logic [AW-1:0]    s,
      input logic [NREGS-1:0] pend,
      input logic             h_vld,
      input logic [AW-1:0]    h_rd,
      input logic             o_vld,
      input logic [AW-1:0]    o_rd
   );
      return (s != '0) && (pend[s] || (h_vld && h_rd == s) || (o_vld && o_rd == s));
   endfunction

   always_comb begin
      alu_ready  = !hold_valid && !rst;
      alu_acc    = bus.alu_valid_in && alu_ready;
      grant      = 1'b0;
      grant_rd   = '0;
      grant_data = '0;
      if (bus.ld_valid_in) begin
         grant      = 1'b1;
         grant_rd   = bus.ld_rd_in;
         grant_data = bus.ld_data_in;
      end else if (hold_valid) begin
         grant      = 1'b1;
         grant_rd   = hold_rd;
         grant_data = hold_data;
      end else if (alu_acc) begin
         grant      = 1'b1;
         grant_rd   = bus.alu_rd_in;
         grant_data = bus.alu_data_in;
      end
   end

   always_comb begin
      pending_nxt = pending;
      if (bus.ld_valid_in)
         pending_nxt[bus.ld_rd_in] = 1'b0;
      // A new issue to the same register outranks the retiring load.
      if (bus.issue_ld_in && bus.issue_rd_in != '0)
         pending_nxt[bus.issue_rd_in] = 1'b1;
      pending_nxt[0] = 1'b0;
      err_set = bus.ld_valid_in && bus.ld_rd_in != '0 && !pending[bus.ld_rd_in];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         hold_valid <= 1'b0;
         pending    <= '0;
         err        <= 1'b0;
         vld_p0     <= 1'b0;
         rd_p0      <= '0;
         data_p0    <= '0;
      end else begin
         pending <= pending_nxt;
         if (err_set)
            err <= 1'b1;
         // Output stage: register file write port
         vld_p0 <= grant && grant_rd != '0;
         if (grant) begin
            rd_p0   <= grant_rd;
            data_p0 <= grant_data;
         end
         if (bus.ld_valid_in) begin
            if (alu_acc) begin
               hold_valid <= 1'b1;
               hold_rd    <= bus.alu_rd_in;
               hold_data  <= bus.alu_data_in;
            end
         end else if (hold_valid) begin
            hold_valid <= 1'b0;
         end
      end
   end

   assign bus.alu_ready_out    = alu_ready;
   assign bus.write_enable_out = vld_p0;
   assign bus.rd_sel_out       = rd_p0;
   assign bus.write_data_out   = data_p0;
   assign bus.pending_out      = pending;
   assign bus.err_out          = err;
   assign bus.hazard_out =
      src_hazard(bus.rs1_sel_in, pending, hold_valid, hold_rd, vld_p0, rd_p0) ||
      src_hazard(bus.rs2_sel_in, pending, hold_valid, hold_rd, vld_p0, rd_p0);

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: a queue-based writeback model checked
// every cycle, plus hand-computed expectations for each scenario.
module tb_regfile_wb_arbiter;
   localparam int XLEN  = 32;
   localparam int NREGS = 32;
   localparam int AW    = 5;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;

   regfile_wb_arbiter_if #(.XLEN(XLEN), .NREGS(NREGS), .AW(AW)) bus ();

   regfile_wb_arbiter #(.XLEN(XLEN), .NREGS(NREGS), .AW(AW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: ALU results waiting for the port are a FIFO; loads always win the port.
   logic [NREGS-1:0] m_pend;
   logic [AW-1:0]    q_rd[$];
   logic [XLEN-1:0]  q_data[$];
   logic             m_we;
   logic [AW-1:0]    m_rd;
   logic [XLEN-1:0]  m_data;
   logic             m_err;
   bit               live = 1'b0;

   logic [NREGS-1:0] np;
   bit               acc;
   bit               g;
   logic [AW-1:0]    grd;
   logic [XLEN-1:0]  gd;

   always @(posedge clk) begin
      if (rst) begin
         m_pend = '0;
         q_rd.delete();
         q_data.delete();
         m_we   = 1'b0;
         m_rd   = '0;
         m_data = '0;
         m_err  = 1'b0;
         live   = 1'b1;
      end else begin
         acc = bus.alu_valid_in && (q_rd.size() == 0);
         np  = m_pend;
         g   = 1'b0;
         grd = '0;
         gd  = '0;
         if (bus.ld_valid_in) begin
            g   = 1'b1;
            grd = bus.ld_rd_in;
            gd  = bus.ld_data_in;
            if (grd != 0 && !m_pend[grd]) m_err = 1'b1;
            np[grd] = 1'b0;
            if (acc) begin
               q_rd.push_back(bus.alu_rd_in);
               q_data.push_back(bus.alu_data_in);
            end
         end else if (q_rd.size() > 0) begin
            g   = 1'b1;
            grd = q_rd.pop_front();
            gd  = q_data.pop_front();
         end else if (acc) begin
            g   = 1'b1;
            grd = bus.alu_rd_in;
            gd  = bus.alu_data_in;
         end
         if (bus.issue_ld_in && bus.issue_rd_in != 0) np[bus.issue_rd_in] = 1'b1;
         np[0]  = 1'b0;
         m_pend = np;
         if (g) begin
            m_rd   = grd;
            m_data = gd;
         end
         m_we = g && grd != 0;
      end
   end

   function automatic bit src_busy(input logic [AW-1:0] s);
      if (s == 0) return 1'b0;
      if (m_pend[s]) return 1'b1;
      foreach (q_rd[i]) if (q_rd[i] == s) return 1'b1;
      return m_we && m_rd == s;
   endfunction

   always @(negedge clk) begin
      if (live) begin
         chk("m_alu_ready", bus.alu_ready_out, !rst && q_rd.size() == 0);
         chk("m_write_enable", bus.write_enable_out, m_we);
         chk("m_rd_sel", bus.rd_sel_out, m_rd);
         chk("m_write_data", bus.write_data_out, m_data);
         chk("m_pending", bus.pending_out, m_pend);
         chk("m_err", bus.err_out, m_err);
         chk("m_hazard", bus.hazard_out, src_busy(bus.rs1_sel_in) || src_busy(bus.rs2_sel_in));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_valids();
      bus.alu_valid_in = 1'b0;
      bus.ld_valid_in  = 1'b0;
      bus.issue_ld_in  = 1'b0;
   endtask

   task automatic alu(input logic [AW-1:0] rd, input logic [XLEN-1:0] d);
      bus.alu_valid_in = 1'b1;
      bus.alu_rd_in    = rd;
      bus.alu_data_in  = d;
   endtask

   task automatic ld(input logic [AW-1:0] rd, input logic [XLEN-1:0] d);
      bus.ld_valid_in = 1'b1;
      bus.ld_rd_in    = rd;
      bus.ld_data_in  = d;
   endtask

   task automatic issue(input logic [AW-1:0] rd);
      bus.issue_ld_in = 1'b1;
      bus.issue_rd_in = rd;
   endtask

   initial begin
      clear_valids();
      bus.alu_rd_in   = '0;
      bus.alu_data_in = '0;
      bus.ld_rd_in    = '0;
      bus.ld_data_in  = '0;
      bus.issue_rd_in = '0;
      bus.rs1_sel_in  = '0;
      bus.rs2_sel_in  = '0;

      // Reset with random inputs
      repeat (2) begin
         tick();
         bus.alu_valid_in = 1'($urandom_range(0, 1));
         bus.alu_rd_in    = AW'($urandom);
         bus.alu_data_in  = $urandom;
         bus.ld_valid_in  = 1'($urandom_range(0, 1));
         bus.ld_rd_in     = AW'($urandom);
         bus.ld_data_in   = $urandom;
         bus.issue_ld_in  = 1'($urandom_range(0, 1));
         bus.issue_rd_in  = AW'($urandom);
         bus.rs1_sel_in   = AW'($urandom);
         bus.rs2_sel_in   = AW'($urandom);
         @(negedge clk);
         chk("rst_ready", bus.alu_ready_out, 0);
         chk("rst_we", bus.write_enable_out, 0);
         chk("rst_rd_sel", bus.rd_sel_out, 0);
         chk("rst_data", bus.write_data_out, 0);
         chk("rst_pending", bus.pending_out, 0);
         chk("rst_err", bus.err_out, 0);
         chk("rst_hazard", bus.hazard_out, 0);
      end
      tick();
      rst = 1'b0;
      clear_valids();
      bus.rs1_sel_in = '0;
      bus.rs2_sel_in = '0;
      @(negedge clk);
      chk("rel_ready", bus.alu_ready_out, 1);
      chk("rel_pending", bus.pending_out, 0);

      // ALU only; also issue a load to x3 for the collision below
      tick();
      alu(5, 32'hDEADBEEF);
      issue(3);
      bus.rs1_sel_in = 5;
      @(negedge clk);
      chk("alu_ready", bus.alu_ready_out, 1);
      tick();
      clear_valids();
      @(negedge clk);
      chk("alu_we", bus.write_enable_out, 1);
      chk("alu_rd", bus.rd_sel_out, 5);
      chk("alu_data", bus.write_data_out, 32'hDEADBEEF);
      chk("alu_hazard_on", bus.hazard_out, 1);
      tick();
      @(negedge clk);
      chk("alu_hazard_off", bus.hazard_out, 0);
      chk("alu_we_off", bus.write_enable_out, 0);

      // Collision
      tick();
      bus.rs1_sel_in = 0;
      bus.rs2_sel_in = 4;
      ld(3, 32'h11);
      alu(4, 32'h22);
      @(negedge clk);
      chk("col_ready0", bus.alu_ready_out, 1);
      tick();
      clear_valids();
      @(negedge clk);
      chk("col1_we", bus.write_enable_out, 1);
      chk("col1_rd", bus.rd_sel_out, 3);
      chk("col1_data", bus.write_data_out, 32'h11);
      chk("col1_ready", bus.alu_ready_out, 0);
      chk("col1_hazard", bus.hazard_out, 1);
      tick();
      @(negedge clk);
      chk("col2_we", bus.write_enable_out, 1);
      chk("col2_rd", bus.rd_sel_out, 4);
      chk("col2_data", bus.write_data_out, 32'h22);
      chk("col2_ready", bus.alu_ready_out, 1);
      chk("col2_hazard", bus.hazard_out, 1);
      chk("col2_err", bus.err_out, 0);
      tick();
      @(negedge clk);
      chk("col3_hazard", bus.hazard_out, 0);

      // Scoreboard
      tick();
      bus.rs2_sel_in = 0;
      bus.rs1_sel_in = 7;
      issue(7);
      tick();
      clear_valids();
      @(negedge clk);
      chk("sb_pend7", bus.pending_out[7], 1);
      chk("sb_hazard", bus.hazard_out, 1);
      tick();
      tick();
      ld(7, 32'h77);
      @(negedge clk);
      chk("sb_hazard_ld", bus.hazard_out, 1);
      tick();
      clear_valids();
      @(negedge clk);
      chk("sb_pend7_clr", bus.pending_out[7], 0);
      chk("sb_we", bus.write_enable_out, 1);
      chk("sb_rd", bus.rd_sel_out, 7);
      chk("sb_data", bus.write_data_out, 32'h77);
      chk("sb_hazard_wb", bus.hazard_out, 1);
      tick();
      @(negedge clk);
      chk("sb_hazard_off", bus.hazard_out, 0);

      // Simultaneous set/clear
      tick();
      bus.rs1_sel_in = 0;
      issue(9);
      tick();
      issue(9);
      ld(9, 32'h99);
      tick();
      clear_valids();
      @(negedge clk);
      chk("sim_pend9", bus.pending_out[9], 1);
      chk("sim_err", bus.err_out, 0);
      chk("sim_we", bus.write_enable_out, 1);
      chk("sim_rd", bus.rd_sel_out, 9);
      tick();
      ld(9, 32'h9A);
      tick();
      clear_valids();
      @(negedge clk);
      chk("sim_pend9_clr", bus.pending_out[9], 0);
      chk("sim_err2", bus.err_out, 0);

      // Error flag and x0
      tick();
      ld(12, 32'hC);
      tick();
      clear_valids();
      @(negedge clk);
      chk("err_set", bus.err_out, 1);
      tick();
      alu(0, 32'h55);
      bus.rs1_sel_in = 0;
      tick();
      clear_valids();
      @(negedge clk);
      chk("x0_we", bus.write_enable_out, 0);
      chk("x0_hazard", bus.hazard_out, 0);
      chk("err_sticky", bus.err_out, 1);

      // Reset mid-operation with a hold entry and pending bits
      tick();
      issue(15);
      tick();
      ld(15, 32'hF);
      alu(20, 32'h14);
      issue(21);
      bus.rs1_sel_in = 20;
      tick();
      clear_valids();
      rst = 1'b1;
      @(negedge clk);
      chk("mid_rst_ready", bus.alu_ready_out, 0);
      tick();
      rst = 1'b0;
      @(negedge clk);
      chk("mid_pending", bus.pending_out, 0);
      chk("mid_err", bus.err_out, 0);
      chk("mid_we", bus.write_enable_out, 0);
      chk("mid_hazard", bus.hazard_out, 0);
      chk("mid_ready", bus.alu_ready_out, 1);
      tick();
      @(negedge clk);
      chk("mid_we2", bus.write_enable_out, 0);

      repeat (3) tick();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Shares the register file's single write port between ALU writeback and load writeback, and keeps a per-register scoreboard of outstanding loads. It sits between the execute/memory stages and the register file. It drives the register file's write-enable, destination-select and write-data inputs from a registered output stage. It gives decode a hazard signal for any source register whose value is not yet readable from the register file.

## Interface
- XLEN, 32, data width
- NREGS, 32, number of architectural registers; register 0 is hard-wired zero
- AW, 5, register index width (log2 NREGS)

- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- alu_valid_in  input  1  ALU writeback request
- alu_rd_in  input  AW  ALU destination
- alu_data_in  input  XLEN  ALU result
- alu_ready_out  output  1  ALU request accepted this cycle when high with alu_valid_in
- ld_valid_in  input  1  load writeback; always accepted, never stalled
- ld_rd_in  input  AW  load destination
- ld_data_in  input  XLEN  load data
- issue_ld_in  input  1  a load is issued this cycle
- issue_rd_in  input  AW  destination of the issued load
- rs1_sel_in, rs2_sel_in  input  AW  decode source selects
- hazard_out  output  1  decode must stall
- write_enable_out  output  1  register file write enable
- rd_sel_out  output  AW  register file destination select
- write_data_out  output  XLEN  register file write data
- pending_out  output  NREGS  scoreboard bits, for debug
- err_out  output  1  sticky error: a load writeback arrived for a non-pending register

## Operation

**State**
- hold buffer: hold_valid, hold_rd, hold_data
- pending[NREGS-1:0]
- output stage registers
- err

**ALU acceptance**
- alu_ready_out = !hold_valid && !rst.
- An ALU request is accepted when alu_valid_in && alu_ready_out.

**Grant, evaluated once per cycle**
1. ld_valid_in: grant the load. An accepted ALU request goes into the hold buffer. An existing hold entry stays.
2. Else if hold_valid: grant the hold entry and clear hold_valid. No ALU request can be accepted this cycle.
3. Else if an ALU request is accepted: grant it directly.
4. Else: idle.

**Output stage, registered**
- write_enable_out = granted && granted_rd != 0.
- rd_sel_out and write_data_out are loaded from the granted source.
- When idle, write_enable_out = 0 and rd_sel_out / write_data_out hold their previous values.

**Scoreboard**
- issue_ld_in with issue_rd_in != 0 sets pending[issue_rd_in].
- A load grant clears pending[ld_rd_in].
- If the same register is set and cleared in the same cycle, set wins.
- pending[0] is always 0.
- Issuing to an already-pending register is legal (WAW) and leaves the bit set.

**Error flag**
- A load grant with ld_rd_in != 0 && !pending[ld_rd_in] sets err, which stays set until rst.

**hazard_out, combinational**
- For each source s in {rs1_sel_in, rs2_sel_in} with s != 0, hazard_out is asserted if any of these holds:
  - pending[s]
  - hold_valid && hold_rd == s
  - write_enable_out && rd_sel_out == s
- hazard_out is 0 for a source select of 0.

## Timing
- Reset, on the clk edge with rst high: hold_valid = 0, pending = 0, err = 0, write_enable_out = 0, rd_sel_out = 0, write_data_out = 0.
- Reset values of the remaining outputs: alu_ready_out = 0 while rst is high; hazard_out = 0 once state is cleared; pending_out = 0; err_out = 0.
- All inputs are ignored while rst is high. Reset mid-operation discards the hold entry and all pending bits.
- Grant to write_enable_out latency is 1 cycle.
- A write presented on the output stage in cycle N is written at the end of cycle N. Its data is readable through the register file's asynchronous read in cycle N+1, when hazard_out for that register drops.
- A held ALU result writes back no later than the first cycle with ld_valid_in low. The ALU stalls (alu_ready_out = 0) for exactly the cycles in which hold_valid = 1.
- Back-to-back loads every cycle starve the ALU indefinitely. This is permitted; the memory stage guarantees gaps.
- pending and err update on the clock edge. pending_out reflects the registered state.

## Test plan
- **Reset:** rst = 1 for 2 cycles with random inputs -> all outputs 0, alu_ready_out = 0; after release, alu_ready_out = 1 and pending_out = 0.
- **ALU only:** alu_valid_in = 1, rd = 5, data = 0xDEADBEEF -> next cycle write_enable_out = 1, rd_sel_out = 5, write_data_out = 0xDEADBEEF; with rs1_sel_in = 5, hazard_out = 1 that cycle and 0 the cycle after.
- **Collision:**
  - Stimulus: same cycle, ld (rd = 3, data = 0x11) and ALU (rd = 4, data = 0x22).
  - Cycle +1: writes rd 3 / 0x11, and alu_ready_out = 0.
  - Cycle +2: writes rd 4 / 0x22, and alu_ready_out = 1.
  - Throughout: hazard_out = 1 for rs2_sel_in = 4 until the rd-4 write leaves the output stage.
- **Scoreboard:** issue_ld_in rd = 7 -> pending_out[7] = 1 and hazard_out = 1 for rs1 = 7; ld_valid_in rd = 7 three cycles later -> pending[7] clears, write appears on the next cycle, hazard_out = 0 one cycle after that.
- **Simultaneous set/clear:** issue_ld_in rd = 9 in the same cycle as ld_valid_in rd = 9 (with pending[9] = 1) -> pending[9] stays 1 and err_out = 0.
- **Error and x0:** ld_valid_in rd = 12 with no pending -> err_out = 1 (sticky); ALU write to rd = 0 -> write_enable_out stays 0, and hazard_out = 0 for rs1 = 0.
